// File: rtl/spi_burst_seq.sv
// spi_burst_seq: burst sequencer between the CPU peripheral bus and one
// icosoc_mod_spi instance. Software queues up to FIFO_DEPTH TX bytes, issues a
// command, and the block walks the SPI module through divider, mode, CS
// assert, a write/read pair per byte and CS release, collecting RX bytes.
// Optional feature macro: SPI_BURST_SEQ_TIMEOUT_EN (per-access watchdog).
module spi_burst_seq #(
  parameter int FIFO_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ctrl_wr,
  input  logic        ctrl_rd,
  input  logic [7:0]  ctrl_addr,
  input  logic [31:0] ctrl_wdat,
  output logic [31:0] ctrl_rdat,
  output logic        ctrl_done,
  output logic        spi_wr,
  output logic        spi_rd,
  output logic [7:0]  spi_addr,
  output logic [31:0] spi_wdat,
  input  logic [31:0] spi_rdat,
  input  logic        spi_done,
  output logic        busy,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [4:0] DEPTH5 = 5'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_DIV, S_MODE, S_CSON, S_TXW, S_RXR, S_CSOFF, S_FIN
  } state_t;

  state_t state, state_nxt;

  logic [15:0] cfg;
  logic [7:0]  b_div;
  logic [1:0]  b_mode;
  logic [4:0]  b_cs;
  logic        b_keep;
  logic [4:0]  remaining;
  logic        done_sticky, err, tmo_flag, start_pend, host_hold;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wp, tx_rp, rx_wp, rx_rp, tx_diff, rx_diff;
  logic [4:0]    tx_lvl, rx_lvl, rx_free;
  logic          tx_full, rx_empty;

  logic host_req, host_acc, wr_cfg, wr_cmd, wr_tx, rd_rx;
  logic [4:0] cmd_n;
  logic cmd_ok, busy_int;
  logic req_active, acc_done, tmo_hit, tx_pop, rx_push, tx_push, rx_pop;
  logic acc_st, acc_rd;
  logic [7:0]  acc_addr, addr_nxt;
  logic [31:0] acc_wdat, wdat_nxt, status;
  logic wr_nxt, rd_nxt;
  logic unused_bits;

  assign unused_bits = ^{ctrl_wdat[31:16], spi_rdat[31:8]};

  assign tx_diff  = tx_wp - tx_rp;
  assign rx_diff  = rx_wp - rx_rp;
  assign tx_lvl   = 5'(tx_diff);
  assign rx_lvl   = 5'(rx_diff);
  assign rx_free  = DEPTH5 - rx_lvl;
  assign tx_full  = (tx_lvl == DEPTH5);
  assign rx_empty = (rx_lvl == 5'd0);

  // A held request is only a new access once it has dropped after its done.
  assign host_req = ctrl_wr | ctrl_rd;
  assign host_acc = host_req & ~ctrl_done & ~host_hold;
  assign wr_cfg   = host_acc & ctrl_wr & (ctrl_addr == 8'h00);
  assign wr_cmd   = host_acc & ctrl_wr & (ctrl_addr == 8'h04);
  assign wr_tx    = host_acc & ctrl_wr & (ctrl_addr == 8'h08);
  assign rd_rx    = host_acc & ~ctrl_wr & ctrl_rd & (ctrl_addr == 8'h0C);

  // start_pend covers the done cycle, before the FSM has left IDLE.
  assign busy     = (state != S_IDLE);
  assign busy_int = busy | start_pend;
  assign cmd_n    = ctrl_wdat[4:0];
  assign cmd_ok   = (cmd_n != 5'd0) && (cmd_n <= DEPTH5) && !busy_int &&
                    (tx_lvl >= cmd_n) && (rx_free >= cmd_n);

  assign status = {11'b0, rx_lvl, 3'b0, tx_lvl, 4'b0, tmo_flag, err, done_sticky, busy};
  assign irq    = done_sticky & cfg[15];

  assign req_active = spi_wr | spi_rd;
  assign acc_done   = req_active & spi_done;
  assign tx_pop     = (state == S_TXW) & acc_done;
  assign rx_push    = (state == S_RXR) & acc_done;
  assign tx_push    = wr_tx & ~tx_full;
  assign rx_pop     = rd_rx & ~rx_empty;

`ifdef SPI_BURST_SEQ_TIMEOUT_EN
  logic [31:0] to_cnt;

  // Count cycles an SPI request has been outstanding without spi_done.
  always_ff @(posedge clk) begin
    if (!resetn)                      to_cnt <= '0;
    else if (req_active && !spi_done) to_cnt <= to_cnt + 32'd1;
    else                              to_cnt <= '0;
  end

  assign tmo_hit = req_active & ~spi_done & (to_cnt == 32'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // TX FIFO pointers: host pushes, the TXW state pops on spi_done.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
    end
  end

  // RX FIFO pointers: the RXR state pushes, host RXDATA reads pop.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
    end
  end

  // FIFO storage, data only, no reset needed.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= ctrl_wdat[7:0];
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= spi_rdat[7:0];
  end

  // Host handshake, register file, status flags and burst parameter latch.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ctrl_done   <= 1'b0;
      ctrl_rdat   <= '0;
      host_hold   <= 1'b0;
      cfg         <= '0;
      start_pend  <= 1'b0;
      b_div       <= '0;
      b_mode      <= '0;
      b_cs        <= '0;
      b_keep      <= 1'b0;
      remaining   <= '0;
      done_sticky <= 1'b0;
      err         <= 1'b0;
      tmo_flag    <= 1'b0;
    end else begin
      ctrl_done  <= host_acc;
      host_hold  <= host_acc | (host_hold & host_req);
      start_pend <= wr_cmd & cmd_ok;
      if (rx_push) remaining <= remaining - 5'd1;
      if (state == S_FIN) done_sticky <= 1'b1;
      if (tmo_hit) begin
        tmo_flag <= 1'b1;
        err      <= 1'b1;
      end
      if (wr_tx && tx_full) err <= 1'b1;
      if (wr_cfg) cfg <= ctrl_wdat[15:0];
      // CMD and STATUS share 0x04: clear bits apply first, a rejection then sets err.
      if (wr_cmd) begin
        if (ctrl_wdat[1]) done_sticky <= 1'b0;
        if (ctrl_wdat[2]) err         <= 1'b0;
        if (ctrl_wdat[3]) tmo_flag    <= 1'b0;
        if (cmd_ok) begin
          b_div       <= cfg[7:0];
          b_mode      <= cfg[9:8];
          b_cs        <= cfg[14:10];
          b_keep      <= ctrl_wdat[8];
          remaining   <= cmd_n;
          done_sticky <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end
      if (host_acc) begin
        ctrl_rdat <= '0;
        if (!ctrl_wr) begin
          unique case (ctrl_addr)
            8'h00:   ctrl_rdat <= {16'b0, cfg};
            8'h04:   ctrl_rdat <= status;
            8'h0C:   ctrl_rdat <= rx_empty ? 32'h8000_0000 : {24'b0, rx_mem[rx_rp[AW-1:0]]};
            default: ctrl_rdat <= '0;
          endcase
        end
      end
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next state: each access state advances once its SPI access completes.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start_pend) state_nxt = S_DIV;
      S_DIV:   if (acc_done) state_nxt = S_MODE;
      S_MODE:  if (acc_done) state_nxt = S_CSON;
      S_CSON:  if (acc_done) state_nxt = S_TXW;
      S_TXW:   if (acc_done) state_nxt = S_RXR;
      S_RXR:   if (acc_done) state_nxt = (remaining != 5'd1) ? S_TXW :
                                         (b_keep ? S_FIN : S_CSOFF);
      S_CSOFF: if (acc_done) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (tmo_hit) state_nxt = S_IDLE;
  end

  // Access decode and next value of the registered SPI master request.
  always_comb begin
    acc_st   = 1'b1;
    acc_rd   = 1'b0;
    acc_addr = 8'h00;
    acc_wdat = '0;
    unique case (state)
      S_DIV:   acc_wdat = {24'b0, b_div};
      S_MODE:  begin acc_addr = 8'h0C; acc_wdat = {30'b0, b_mode}; end
      S_CSON:  begin acc_addr = 8'h04; acc_wdat = ~(32'b1 << b_cs); end
      S_TXW:   begin acc_addr = 8'h08; acc_wdat = {24'b0, tx_mem[tx_rp[AW-1:0]]}; end
      S_RXR:   begin acc_addr = 8'h08; acc_rd = 1'b1; end
      S_CSOFF: begin acc_addr = 8'h04; acc_wdat = 32'hFFFF_FFFF; end
      default: acc_st = 1'b0;
    endcase
    wr_nxt   = spi_wr;
    rd_nxt   = spi_rd;
    addr_nxt = spi_addr;
    wdat_nxt = spi_wdat;
    // The cycle after spi_done the request is low, which gives the idle gap.
    if (req_active) begin
      if (spi_done || tmo_hit) begin
        wr_nxt = 1'b0;
        rd_nxt = 1'b0;
      end
    end else if (acc_st) begin
      wr_nxt   = ~acc_rd;
      rd_nxt   = acc_rd;
      addr_nxt = acc_addr;
      wdat_nxt = acc_wdat;
    end
  end

  // Registered SPI master outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      spi_wr   <= 1'b0;
      spi_rd   <= 1'b0;
      spi_addr <= '0;
      spi_wdat <= '0;
    end else begin
      spi_wr   <= wr_nxt;
      spi_rd   <= rd_nxt;
      spi_addr <= addr_nxt;
      spi_wdat <= wdat_nxt;
    end
  end
endmodule
